// File: rtl/hw_interrupt_request_controller.sv
// Interrupt request conditioning for the six external MIPS interrupt lines:
// synchronizer, optional rising-edge latch, and a presentation FSM that holds
// hardware_int stable under stall and blanks it after an acknowledge.
module hw_interrupt_request_controller #(
    parameter int unsigned N_INT        = 6,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_INT-1:0] int_raw,
    input  logic [N_INT-1:0] edge_mode,
    input  logic [N_INT-1:0] clear_pending,
    input  logic             stall,
    input  logic             accept_hardware_interrupt,
    input  logic [N_INT-1:0] taken_int,
    output logic [N_INT-1:0] hardware_int,
    output logic [N_INT-1:0] pending,
    output logic             busy
);

    localparam int unsigned CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_BLANK   = 2'd2;

    logic [SYNC_STAGES-1:0][N_INT-1:0] sync_q;
    logic [N_INT-1:0]                  sync_c;
    logic [N_INT-1:0]                  sync_prev_q;
    logic [N_INT-1:0]                  edge_q, edge_d;
    logic [N_INT-1:0]                  rise_c, clr_c;

    logic [1:0]       state_q, state_d;
    logic [N_INT-1:0] snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_INT-1:0] hw_q, hw_d;
    logic             busy_q, busy_d;
    logic             ack_c;

    assign sync_c  = sync_q[SYNC_STAGES-1];
    assign pending = (edge_mode & edge_q) | (~edge_mode & sync_c);

    // Edge latch: a new rising edge beats any clear; leaving edge mode drops the latch.
    always_comb begin
        rise_c = sync_c & ~sync_prev_q;
        clr_c  = clear_pending | (ack_c ? taken_int : '0);
        edge_d = edge_mode & (rise_c | (edge_q & ~clr_c));
    end

    // Synchronizer chain, previous-sync copy and edge latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            sync_prev_q <= '0;
            edge_q      <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], int_raw};
            sync_prev_q <= sync_c;
            edge_q      <= edge_d;
        end
    end

    // Presentation FSM next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        ack_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    snap_d  = pending;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (accept_hardware_interrupt) begin
                    // A stalled acknowledge cannot commit: hold everything.
                    if (!stall) begin
                        ack_c   = 1'b1;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_BLANK;
                    end
                end else begin
                    snap_d = snap_q & pending;
                    if (snap_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BLANK: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        hw_d   = (state_d == ST_PRESENT) ? snap_d : '0;
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, snapshot, blank counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
            hw_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            hw_q    <= hw_d;
            busy_q  <= busy_d;
        end
    end

    assign hardware_int = hw_q;
    assign busy         = busy_q;

endmodule
